// File: rtl/axil_pkg.sv
// Shared AXI-Lite types: response codes, read-channel FSM states and the
// native data width used by the register-file side of the link.
package axil_pkg;

  localparam int AXIL_DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    RESP
  } rd_state_t;

endpackage

// File: rtl/axils_rd_ch.sv
// AXI-Lite slave read channel: one outstanding read, decode/alignment check,
// fixed-latency register-file access. Define AXILS_RD_PROT_CHECK_EN to reject non-secure reads.
module axils_rd_ch
  import axil_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = AXIL_DATA_W,
  parameter int REG_NUM = 64,
  parameter int RD_LAT  = 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              REG_RD_EN,
  output logic [ADDR_W-3:0] REG_RD_ADDR,
  input  logic [DATA_W-1:0] REG_RD_DATA,
  input  logic              REG_RD_ERR
);

  // state     | meaning
  // IDLE      | ARREADY high, waiting for an AR handshake
  // ISSUE     | one-cycle backend read strobe, latency counter loaded
  // WAIT_DATA | counting down to the cycle the backend data is valid
  // RESP      | RVALID high, response held until RREADY

  localparam logic [31:0] REG_BYTES = 32'(REG_NUM * 4);

  rd_state_t         state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  resp_t             rresp_q;
  logic              rd_en_q;
  logic [ADDR_W-3:0] rd_addr_q;
  logic [2:0]        cnt_q;

  logic [31:0] araddr_ext;
  logic        ar_hs;
  logic        err_hit_d;
  resp_t       err_resp_d;
  logic        prot_denied;

  assign araddr_ext = 32'(ARADDR);
  assign ar_hs      = ARVALID && arready_q;

`ifdef AXILS_RD_PROT_CHECK_EN
  logic unused_prot;
  assign prot_denied = ARPROT[1];
  assign unused_prot = ^{ARPROT[2], ARPROT[0]};
`else
  logic unused_prot;
  assign prot_denied = 1'b0;
  assign unused_prot = ^ARPROT;
`endif

  // Alignment beats decode beats protection.
  always_comb begin
    err_hit_d  = 1'b1;
    err_resp_d = SLVERR;
    if (ARADDR[1:0] != 2'b00) begin
      err_resp_d = SLVERR;
    end else if (araddr_ext >= REG_BYTES) begin
      err_resp_d = DECERR;
    end else if (prot_denied) begin
      err_resp_d = SLVERR;
    end else begin
      err_hit_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rd_addr_q <= ARADDR[ADDR_W-1:2];
            if (err_hit_d) begin
              rvalid_q <= 1'b1;
              rdata_q  <= '0;
              rresp_q  <= err_resp_d;
              state_q  <= RESP;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          rd_en_q <= 1'b0;
          cnt_q   <= 3'(RD_LAT);
          state_q <= WAIT_DATA;
        end
        WAIT_DATA: begin
          cnt_q <= cnt_q - 3'd1;
          // Counter reaching zero lines up with the backend's data-valid cycle.
          if (cnt_q == 3'd1) begin
            rdata_q  <= REG_RD_DATA;
            rresp_q  <= REG_RD_ERR ? SLVERR : OKAY;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARREADY     = arready_q;
  assign RVALID      = rvalid_q;
  assign RDATA       = rdata_q;
  assign RRESP       = rresp_q;
  assign REG_RD_EN   = rd_en_q;
  assign REG_RD_ADDR = rd_addr_q;

endmodule

// File: tb/tb_axils_rd_ch.sv
// Bench for axils_rd_ch: two instances (RD_LAT=1 and RD_LAT=4), vector table,
// hand-written corner sequences and randomized reads against a reference model.
module tb_axils_rd_ch;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int REG_NUM = 64;
`ifdef AXILS_RD_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESETn;

  logic              arvalid[2], arready[2], rvalid[2], rready[2];
  logic              reg_rd_en[2], reg_rd_err[2];
  logic [ADDR_W-1:0] araddr[2];
  logic [2:0]        arprot[2];
  logic [DATA_W-1:0] rdata[2], reg_rd_data[2];
  logic [1:0]        rresp[2];
  logic [ADDR_W-3:0] reg_rd_addr[2];

  axils_rd_ch #(.RD_LAT(1)) u_lat1 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(arvalid[0]), .ARREADY(arready[0]), .ARADDR(araddr[0]), .ARPROT(arprot[0]),
    .RVALID(rvalid[0]), .RREADY(rready[0]), .RDATA(rdata[0]), .RRESP(rresp[0]),
    .REG_RD_EN(reg_rd_en[0]), .REG_RD_ADDR(reg_rd_addr[0]),
    .REG_RD_DATA(reg_rd_data[0]), .REG_RD_ERR(reg_rd_err[0])
  );

  axils_rd_ch #(.RD_LAT(4)) u_lat4 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(arvalid[1]), .ARREADY(arready[1]), .ARADDR(araddr[1]), .ARPROT(arprot[1]),
    .RVALID(rvalid[1]), .RREADY(rready[1]), .RDATA(rdata[1]), .RRESP(rresp[1]),
    .REG_RD_EN(reg_rd_en[1]), .REG_RD_ADDR(reg_rd_addr[1]),
    .REG_RD_DATA(reg_rd_data[1]), .REG_RD_ERR(reg_rd_err[1])
  );

  logic [31:0] mem [REG_NUM];
  bit          err_mem [REG_NUM];

  // Backend: data valid only in the cycle RD_LAT after the strobe, garbage otherwise.
  for (genvar g = 0; g < 2; g++) begin : g_be
    localparam int LAT = (g == 0) ? 1 : 4;
    logic        pv [4];
    logic [9:0]  pa [4];
    logic [31:0] junk;
    always @(posedge ACLK) begin
      pv[0] <= reg_rd_en[g];
      pa[0] <= reg_rd_addr[g];
      junk  <= $urandom;
      for (int k = 1; k < 4; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end
    assign reg_rd_data[g] = pv[LAT-1] ? mem[pa[LAT-1][5:0]] : junk;
    assign reg_rd_err[g]  = pv[LAT-1] ? err_mem[pa[LAT-1][5:0]] : junk[0];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference model straight from the read rules.
  function automatic void model(input logic [11:0] addr, input logic [2:0] prot,
                                output logic [1:0] resp, output logic [31:0] data,
                                output bit errp);
    int a;
    a = int'(addr);
    errp = 1'b1;
    data = 32'h0;
    if (a % 4 != 0)                resp = 2'd2;
    else if (a >= REG_NUM * 4)     resp = 2'd3;
    else if (PROT_EN && prot[1])   resp = 2'd2;
    else begin
      errp = 1'b0;
      data = mem[a / 4];
      resp = err_mem[a / 4] ? 2'd2 : 2'd0;
    end
  endfunction

  task automatic do_read(input int d, input logic [11:0] addr, input logic [2:0] prot,
                         input int hold, output logic [1:0] resp, output logic [31:0] data,
                         output int rv_cyc, output int en_cnt, output int en_cyc,
                         output logic [9:0] en_addr, output bit stable_ok,
                         output bit ar_after, output bit rv_after, output bit tmo);
    int n, cyc, held;
    resp = '0; data = '0; rv_cyc = -1; en_cnt = 0; en_cyc = -1; en_addr = '0;
    stable_ok = 1'b1; ar_after = 1'b0; rv_after = 1'b1; tmo = 1'b0; held = 0;
    arvalid[d] = 1'b1; araddr[d] = addr; arprot[d] = prot; rready[d] = 1'b0;
    n = 0;
    while (!arready[d] && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!arready[d]) begin
      tmo = 1'b1;
      arvalid[d] = 1'b0;
      return;
    end
    @(negedge ACLK);
    arvalid[d] = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      if (reg_rd_en[d]) begin
        en_cnt++;
        if (en_cyc < 0) begin
          en_cyc  = cyc;
          en_addr = reg_rd_addr[d];
        end
      end
      if (rvalid[d]) begin
        if (rv_cyc < 0) begin
          rv_cyc = cyc;
          resp   = rresp[d];
          data   = rdata[d];
        end else if (rresp[d] !== resp || rdata[d] !== data) begin
          stable_ok = 1'b0;
        end
        if (held >= hold) begin
          rready[d] = 1'b1;
          @(negedge ACLK);
          rready[d] = 1'b0;
          ar_after = arready[d];
          rv_after = rvalid[d];
          if (reg_rd_en[d]) en_cnt++;
          return;
        end
        held++;
      end
      @(negedge ACLK);
      cyc++;
    end
    tmo = 1'b1;
  endtask

  task automatic run_vec(input string tag, input int d, input logic [11:0] addr,
                         input logic [2:0] prot, input int hold, input logic [1:0] eresp,
                         input logic [31:0] edata, input bit errp);
    logic [1:0] resp; logic [31:0] data; logic [9:0] en_addr;
    int rv_cyc, en_cnt, en_cyc;
    bit stable_ok, ar_after, rv_after, tmo;
    string nm;
    nm = $sformatf("%s dut%0d addr=%03h", tag, d, addr);
    do_read(d, addr, prot, hold, resp, data, rv_cyc, en_cnt, en_cyc, en_addr,
            stable_ok, ar_after, rv_after, tmo);
    chk({nm, " timeout"}, 32'(tmo), 32'd0);
    chk({nm, " rresp"}, 32'(resp), 32'(eresp));
    chk({nm, " rdata"}, data, edata);
    chk({nm, " rvalid_cycle"}, rv_cyc, errp ? 1 : lat_of(d) + 2);
    chk({nm, " strobe_count"}, en_cnt, errp ? 0 : 1);
    if (!errp) begin
      chk({nm, " strobe_cycle"}, en_cyc, 1);
      chk({nm, " strobe_addr"}, 32'(en_addr), 32'(addr[11:2]));
    end
    chk({nm, " r_stable"}, 32'(stable_ok), 32'd1);
    chk({nm, " arready_after_r"}, 32'(ar_after), 32'd1);
    chk({nm, " rvalid_dropped"}, 32'(rv_after), 32'd0);
  endtask

  typedef struct packed {
    logic [11:0] addr;
    logic [2:0]  prot;
    logic [1:0]  resp;
    logic [31:0] data;
    bit          errp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [1:0] r0; logic [31:0] d0;
    int n, cyc, busy_acc, stale;
    bit stable;

    ARESETn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      arvalid[d] = 1'b0; araddr[d] = '0; arprot[d] = '0; rready[d] = 1'b0;
    end
    for (int i = 0; i < REG_NUM; i++) begin
      mem[i]     = 32'hC0DE0000 | 32'(i);
      err_mem[i] = (i == 7);
    end
    mem[4] = 32'hDEADBEEF;

    vecs.push_back('{12'h010, 3'b000, 2'd0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{12'h013, 3'b000, 2'd2, 32'h0,        1'b1});
    vecs.push_back('{12'h100, 3'b000, 2'd3, 32'h0,        1'b1});
    vecs.push_back('{12'h0FC, 3'b000, 2'd0, 32'hC0DE003F, 1'b0});
    vecs.push_back('{12'h000, 3'b000, 2'd0, 32'hC0DE0000, 1'b0});
    vecs.push_back('{12'h01C, 3'b000, 2'd2, 32'hC0DE0007, 1'b0});
    vecs.push_back('{12'h102, 3'b000, 2'd2, 32'h0,        1'b1});
    vecs.push_back('{12'hFFC, 3'b000, 2'd3, 32'h0,        1'b1});
    vecs.push_back('{12'h101, 3'b010, 2'd2, 32'h0,        1'b1});
    vecs.push_back('{12'h104, 3'b010, 2'd3, 32'h0,        1'b1});
    vecs.push_back('{12'h024, 3'b101, 2'd0, 32'hC0DE0009, 1'b0});
    if (PROT_EN) vecs.push_back('{12'h020, 3'b010, 2'd2, 32'h0,        1'b1});
    else         vecs.push_back('{12'h020, 3'b010, 2'd0, 32'hC0DE0008, 1'b0});

    repeat (2) @(negedge ACLK);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset dut%0d arready", d), 32'(arready[d]), 32'd0);
      chk($sformatf("reset dut%0d rvalid", d), 32'(rvalid[d]), 32'd0);
      chk($sformatf("reset dut%0d rdata", d), rdata[d], 32'd0);
      chk($sformatf("reset dut%0d rresp", d), 32'(rresp[d]), 32'd0);
      chk($sformatf("reset dut%0d reg_rd_en", d), 32'(reg_rd_en[d]), 32'd0);
      chk($sformatf("reset dut%0d reg_rd_addr", d), 32'(reg_rd_addr[d]), 32'd0);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    for (int d = 0; d < 2; d++)
      chk($sformatf("release dut%0d arready", d), 32'(arready[d]), 32'd1);

    for (int d = 0; d < 2; d++)
      foreach (vecs[i])
        run_vec($sformatf("vec%0d", i), d, vecs[i].addr, vecs[i].prot, 0,
                vecs[i].resp, vecs[i].data, vecs[i].errp);

    // RREADY held low 5 cycles while a second request waits on ARVALID.
    arvalid[0] = 1'b1; araddr[0] = 12'h014; arprot[0] = 3'b000; rready[0] = 1'b0;
    n = 0;
    while (!arready[0] && n < 20) begin @(negedge ACLK); n++; end
    chk("hold ar_accept", 32'(arready[0]), 32'd1);
    @(negedge ACLK);
    araddr[0] = 12'h023;
    cyc = 1; busy_acc = 0; stable = 1'b1;
    while (cyc < 40 && !rvalid[0]) begin
      if (arready[0]) busy_acc++;
      @(negedge ACLK);
      cyc++;
    end
    chk("hold rvalid_cycle", cyc, 3);
    r0 = rresp[0]; d0 = rdata[0];
    for (int k = 0; k < 5; k++) begin
      if (arready[0]) busy_acc++;
      if (!rvalid[0] || rresp[0] !== r0 || rdata[0] !== d0) stable = 1'b0;
      @(negedge ACLK);
    end
    if (!rvalid[0] || rresp[0] !== r0 || rdata[0] !== d0) stable = 1'b0;
    if (arready[0]) busy_acc++;
    chk("hold r_stable", 32'(stable), 32'd1);
    chk("hold busy_accepts", busy_acc, 0);
    chk("hold rdata", d0, 32'hC0DE0005);
    chk("hold rresp", 32'(r0), 32'd0);
    rready[0] = 1'b1;
    @(negedge ACLK);
    rready[0] = 1'b0;
    chk("hold arready_after_r", 32'(arready[0]), 32'd1);
    chk("hold rvalid_dropped", 32'(rvalid[0]), 32'd0);
    @(negedge ACLK);
    arvalid[0] = 1'b0;
    chk("second rvalid", 32'(rvalid[0]), 32'd1);
    chk("second rresp", 32'(rresp[0]), 32'd2);
    chk("second rdata", rdata[0], 32'd0);
    chk("second no_strobe", 32'(reg_rd_en[0]), 32'd0);
    rready[0] = 1'b1;
    @(negedge ACLK);
    rready[0] = 1'b0;

    // Reset pulse while the RD_LAT=4 instance sits in WAIT_DATA.
    arvalid[1] = 1'b1; araddr[1] = 12'h008; arprot[1] = 3'b000;
    n = 0;
    while (!arready[1] && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    arvalid[1] = 1'b0;
    chk("rst strobe_seen", 32'(reg_rd_en[1]), 32'd1);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    chk("rst arready", 32'(arready[1]), 32'd0);
    chk("rst rvalid", 32'(rvalid[1]), 32'd0);
    chk("rst rdata", rdata[1], 32'd0);
    chk("rst rresp", 32'(rresp[1]), 32'd0);
    chk("rst reg_rd_en", 32'(reg_rd_en[1]), 32'd0);
    chk("rst reg_rd_addr", 32'(reg_rd_addr[1]), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rst arready_first_cycle", 32'(arready[1]), 32'd1);
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      if (rvalid[1] || reg_rd_en[1]) stale++;
      @(negedge ACLK);
    end
    chk("rst no_stale_response", stale, 0);

    for (int it = 0; it < 40; it++) begin
      int d, mode, hold;
      logic [11:0] addr; logic [2:0] prot;
      logic [1:0] eresp; logic [31:0] edata; bit errp;
      d    = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      if (mode < 2)       addr = 12'($urandom_range(0, REG_NUM - 1) * 4);
      else if (mode == 2) addr = 12'($urandom);
      else                addr = 12'($urandom_range(0, REG_NUM - 1) * 4 + $urandom_range(1, 3));
      prot = 3'($urandom);
      hold = int'($urandom_range(0, 3));
      model(addr, prot, eresp, edata, errp);
      run_vec($sformatf("rand%0d", it), d, addr, prot, hold, eresp, edata, errp);
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
